hazard_unit: RTL and testbench

Parametrised scoreboard, forwarding and squash controller for the integer pipeline. It tracks every in-flight instruction from EX to commit and selects the youngest ready producer for each source operand. It stalls issue on load-use hazards and squashes a configurable number of wrong-path issues after a taken branch. It replaces the hard-wired 2-stage forwarding, the fixed 2-cycle branch kill and the per-flag delay chains in the core top, and it adds load-use stalling, which the current core lacks.

---
 rtl/core_pkg.sv | 21 ++
 rtl/fwd_select.sv | 54 +++++
 rtl/hazard_unit.sv | 127 ++++++++++++
 tb/tb_hazard_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared integer-pipeline definitions.
// Holds the default operand and register-index widths and the scoreboard entry
// type tracked by hazard_unit from EX to writeback.
package core_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RA_W_DEF = 5;

    // The entry struct cannot follow a module parameter, so rd is sized for the
    // widest register index any core configuration uses. Narrower indices are
    // zero-extended on entry, which keeps equality matches exact.
    localparam int unsigned RA_W_MAX = 8;

    typedef struct packed {
        logic                valid;
        logic [RA_W_MAX-1:0] rd;
        logic                regwrite;
        logic                is_load;
    } sb_entry_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding selector for one source operand.
// Priority-matches rs against the in-flight scoreboard entries (entry 0 is the
// youngest), applies the load-ready check, and returns the operand together
// with a hazard flag when the winning producer's data is not yet available.
//   rs         : source register index from ID
//   rf_rdata   : register-file read data for rs
//   entries    : scoreboard entries, index 0 = EX
//   stage_data : result held by each entry, entry i in [i*XLEN +: XLEN]
//   operand    : resolved operand value (x0 always reads as zero)
//   hazard     : youngest producer is a load whose data is not yet valid
module fwd_select
    import core_pkg::*;
#(
    parameter int unsigned STAGES     = 3,
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned RA_W       = RA_W_DEF,
    parameter int unsigned LOAD_STAGE = 2
) (
    input  logic [RA_W-1:0]        rs,
    input  logic [XLEN-1:0]        rf_rdata,
    input  sb_entry_t              entries [STAGES],
    input  logic [STAGES*XLEN-1:0] stage_data,
    output logic [XLEN-1:0]        operand,
    output logic                   hazard
);

    logic [RA_W_MAX-1:0] rs_ext;
    logic                found;

    assign rs_ext = RA_W_MAX'(rs);

    always_comb begin
        operand = rf_rdata;
        hazard  = 1'b0;
        found   = 1'b0;
        // Lowest index wins: once a producer is found, older entries are ignored.
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (!found && entries[i].valid && entries[i].regwrite &&
                entries[i].rd == rs_ext) begin
                found = 1'b1;
                if (entries[i].is_load && i < LOAD_STAGE) begin
                    hazard = 1'b1;
                end else begin
                    operand = stage_data[i*XLEN +: XLEN];
                end
            end
        end
        if (rs == '0) begin
            operand = '0;
            hazard  = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Scoreboard, forwarding and squash controller for the integer pipeline.
// Tracks every issued instruction from EX to writeback, resolves ID operands
// from the youngest ready producer, stalls on load-use hazards and squashes
// FLUSH_DEPTH issue slots after a taken branch.
//   clk, rst              : clock, synchronous active-high reset
//   id_valid/rs1/rs2/rd   : decoded instruction in ID
//   id_regwrite/is_load   : ID instruction writes rd / takes its result from memory
//   rf_rdata1/2           : register-file data for id_rs1/id_rs2
//   stage_data            : result held by each tracked entry
//   ex_branch_taken       : redirect from entry 0 (ignored when entry 0 is invalid)
//   stall, issue          : combinational ID control
//   ex_valid, ex_op1/2    : registered EX entry valid and resolved operands
//   wb_valid, wb_we, wb_rd: last-entry status and register-file write control
module hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned RA_W        = RA_W_DEF,
    parameter int unsigned LOAD_STAGE  = 2,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [RA_W-1:0]        id_rs1,
    input  logic [RA_W-1:0]        id_rs2,
    input  logic [RA_W-1:0]        id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_is_load,
    input  logic [XLEN-1:0]        rf_rdata1,
    input  logic [XLEN-1:0]        rf_rdata2,
    input  logic [STAGES*XLEN-1:0] stage_data,
    input  logic                   ex_branch_taken,
    output logic                   stall,
    output logic                   issue,
    output logic                   ex_valid,
    output logic [XLEN-1:0]        ex_op1,
    output logic [XLEN-1:0]        ex_op2,
    output logic                   wb_valid,
    output logic                   wb_we,
    output logic [RA_W-1:0]        wb_rd
);

    localparam int unsigned KILL_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [KILL_W-1:0] KILL_LOAD = KILL_W'(FLUSH_DEPTH - 1);

    sb_entry_t         sb [STAGES];
    sb_entry_t         id_entry;
    logic [KILL_W-1:0] kill;
    logic              branch_taken;
    logic              squash;
    logic [XLEN-1:0]   op1, op2;
    logic              haz1, haz2;

    fwd_select #(
        .STAGES    (STAGES),
        .XLEN      (XLEN),
        .RA_W      (RA_W),
        .LOAD_STAGE(LOAD_STAGE)
    ) u_fwd_rs1 (
        .rs        (id_rs1),
        .rf_rdata  (rf_rdata1),
        .entries   (sb),
        .stage_data(stage_data),
        .operand   (op1),
        .hazard    (haz1)
    );

    fwd_select #(
        .STAGES    (STAGES),
        .XLEN      (XLEN),
        .RA_W      (RA_W),
        .LOAD_STAGE(LOAD_STAGE)
    ) u_fwd_rs2 (
        .rs        (id_rs2),
        .rf_rdata  (rf_rdata2),
        .entries   (sb),
        .stage_data(stage_data),
        .operand   (op2),
        .hazard    (haz2)
    );

    // Squash overrides stall: a wrong-path instruction is dropped, not held.
    assign branch_taken = ex_branch_taken & sb[0].valid;
    assign squash       = (kill != '0) | branch_taken;
    assign stall        = id_valid & (haz1 | haz2) & ~squash;
    assign issue        = id_valid & ~stall & ~squash;

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = 1'b1;
        id_entry.rd       = RA_W_MAX'(id_rd);
        id_entry.regwrite = id_regwrite;
        id_entry.is_load  = id_is_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sb[i] <= '0;
            end
            kill   <= '0;
            ex_op1 <= '0;
            ex_op2 <= '0;
        end else begin
            sb[0] <= issue ? id_entry : '0;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sb[i] <= sb[i-1];
            end
            if (branch_taken) begin
                kill <= KILL_LOAD;
            end else if (kill != '0) begin
                kill <= kill - KILL_W'(1);
            end
            ex_op1 <= issue ? op1 : '0;
            ex_op2 <= issue ? op2 : '0;
        end
    end

    assign ex_valid = sb[0].valid;
    assign wb_valid = sb[STAGES-1].valid;
    assign wb_rd    = sb[STAGES-1].rd[RA_W-1:0];
    assign wb_we    = sb[STAGES-1].valid & sb[STAGES-1].regwrite &
                      (sb[STAGES-1].rd != '0);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit (STAGES=3, LOAD_STAGE=2, FLUSH_DEPTH=2).
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_regwrite, id_is_load;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [95:0] stage_data;
    logic        ex_branch_taken;
    logic        stall, issue, ex_valid, wb_valid, wb_we;
    logic [31:0] ex_op1, ex_op2;
    logic [4:0]  wb_rd;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_unit #(
        .STAGES     (3),
        .XLEN       (32),
        .RA_W       (5),
        .LOAD_STAGE (2),
        .FLUSH_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_regwrite    (id_regwrite),
        .id_is_load     (id_is_load),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .stage_data     (stage_data),
        .ex_branch_taken(ex_branch_taken),
        .stall          (stall),
        .issue          (issue),
        .ex_valid       (ex_valid),
        .ex_op1         (ex_op1),
        .ex_op2         (ex_op2),
        .wb_valid       (wb_valid),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] d, input logic we, input logic ld);
        id_valid    = v;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = d;
        id_regwrite = we;
        id_is_load  = ld;
    endtask

    task automatic set_sd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        stage_data = {d2, d1, d0};
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        ex_branch_taken = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rf_rdata1 = 32'h0;
        rf_rdata2 = 32'h0;
        set_sd(32'h0, 32'h0, 32'h0);
        ex_branch_taken = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_ex_op1", ex_op1, 0);
        chk("rst_issue", issue, 0);
        rst = 1'b0;

        // 1: forward from EX
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        rf_rdata1 = 32'hDEAD;
        rf_rdata2 = 32'hDEAD;
        #1;
        chk("t1_issue_addi", issue, 1);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
        set_sd(32'h1234, 32'h0, 32'h0);
        #1;
        chk("t1_stall", stall, 0);
        chk("t1_issue", issue, 1);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("t1_ex_valid", ex_valid, 1);
        chk("t1_ex_op1", ex_op1, 32'h1234);
        chk("t1_ex_op2", ex_op2, 32'h1234);
        tick();
        chk("t1_wb_valid", wb_valid, 1);
        chk("t1_wb_we", wb_we, 1);
        chk("t1_wb_rd", wb_rd, 5);
        drain();

        // 2: load-use stall for LOAD_STAGE cycles
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
        #1;
        chk("t2_issue_lw", issue, 1);
        tick();
        set_id(1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0);
        rf_rdata1 = 32'h1111;
        rf_rdata2 = 32'h5555;
        set_sd(32'hAAAA, 32'hBBBB, 32'hCAFE0000);
        #1;
        chk("t2_stall_c1", stall, 1);
        chk("t2_issue_c1", issue, 0);
        tick();
        chk("t2_stall_c2", stall, 1);
        chk("t2_issue_c2", issue, 0);
        chk("t2_bubble", ex_valid, 0);
        tick();
        chk("t2_stall_c3", stall, 0);
        chk("t2_issue_c3", issue, 1);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("t2_ex_valid", ex_valid, 1);
        chk("t2_ex_op1", ex_op1, 32'hCAFE0000);
        chk("t2_ex_op2_x0", ex_op2, 0);
        drain();

        // 3: youngest producer wins
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        tick();
        set_id(1'b1, 5'd7, 5'd9, 5'd10, 1'b1, 1'b0);
        rf_rdata1 = 32'h77;
        rf_rdata2 = 32'h99;
        set_sd(32'h11, 32'h22, 32'h33);
        #1;
        chk("t3_issue", issue, 1);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("t3_ex_op1", ex_op1, 32'h11);
        chk("t3_ex_op2_rf", ex_op2, 32'h99);
        drain();

        // 4: x0 never forwards and never writes
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
        rf_rdata1 = 32'hFFFFFFFF;
        rf_rdata2 = 32'hFFFFFFFF;
        set_sd(32'hABCD, 32'h0, 32'h0);
        #1;
        chk("t4_issue", issue, 1);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("t4_ex_op1", ex_op1, 0);
        chk("t4_ex_op2", ex_op2, 0);
        tick();
        chk("t4_wb_valid", wb_valid, 1);
        chk("t4_wb_we_x0", wb_we, 0);
        tick();
        chk("t4_wb_we_x1", wb_we, 1);
        chk("t4_wb_rd_x1", wb_rd, 1);
        drain();

        // 5: taken branch squashes two slots, overriding a load-use stall
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        chk("t5_stall_sq", stall, 0);
        chk("t5_issue_s1", issue, 0);
        tick();
        chk("t5_ex_valid", ex_valid, 0);
        chk("t5_issue_s2", issue, 0);
        chk("t5_stall_s2", stall, 0);
        tick();
        chk("t5_issue_s3", issue, 1);
        chk("t5_stall_s3", stall, 0);
        drain();

        // 6: reset mid-flight clears entries and pending squash
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        tick();
        chk("t6_pre_ex_valid", ex_valid, 1);
        chk("t6_pre_wb_valid", wb_valid, 1);
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        rst = 1'b1;
        set_sd(32'h5A5A5A5A, 32'hA5A5A5A5, 32'h12345678);
        #1;
        chk("t6_issue_sq", issue, 0);
        tick();
        rst = 1'b0;
        ex_branch_taken = 1'b0;
        #1;
        chk("t6_ex_valid", ex_valid, 0);
        chk("t6_wb_valid", wb_valid, 0);
        chk("t6_wb_we", wb_we, 0);
        chk("t6_ex_op1", ex_op1, 0);
        chk("t6_issue", issue, 1);
        chk("t6_stall", stall, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
